// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : shared types and constants for the framed program loader
// Revision 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    LEN_LO  = 3'd3,
    LEN_HI  = 3'd4,
    DATA    = 3'd5,
    CSUM    = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_TIMEOUT   = 1024;

endpackage

`default_nettype wire

// File: rtl/prog_loader_timeout.sv
// ============================================================================
// loader_timeout : idle-clock counter, cleared on every accepted byte
// Revision 1.0
// ============================================================================
`default_nettype none

module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count holds the number of completed idle clocks; the TIMEOUT-th idle clock
  // is the one in which expired is raised, regardless of any accept in it
  always_ff @(posedge clock) begin
    if (reset || !enable || clear) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : framed byte-stream loader writing processor working memory
// Revision 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int                TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam int LEN_W = 2 * DATA_W;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                expired;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   csum_total;
  logic [DATA_W-1:0]   len_lo;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    frame_len;
  logic [ADDR_W-1:0]   waddr;

  assign accept     = s_valid && s_ready;
  assign csum_total = sum + s_data;
  assign frame_len  = {s_data, len_lo};

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .enable  (state != IDLE),
    .clear   (accept),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (expired) begin
      state_nxt = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    if (s_data == SYNC_BYTE) state_nxt = ADDR_LO;
        ADDR_LO: state_nxt = ADDR_HI;
        ADDR_HI: state_nxt = LEN_LO;
        LEN_LO:  state_nxt = LEN_HI;
        LEN_HI:  state_nxt = (frame_len == '0) ? CSUM : DATA;
        DATA:    if (remaining == LEN_W'(1)) state_nxt = CSUM;
        CSUM:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      err_code  <= ERR_NONE;
      sum       <= '0;
      len_lo    <= '0;
      remaining <= '0;
      waddr     <= '0;
    end else begin
      s_ready   <= 1'b1;
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      // expiry wins over any byte arriving in the same cycle; that byte is lost
      if (expired) begin
        cpu_hold <= 1'b0;
        load_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (accept) begin
        case (state)
          IDLE: begin
            if (s_data == SYNC_BYTE) begin
              cpu_hold <= 1'b1;
              err_code <= ERR_NONE;
              sum      <= '0;
            end
          end
          ADDR_LO: begin
            waddr[DATA_W-1:0] <= s_data;
            sum               <= csum_total;
          end
          ADDR_HI: begin
            waddr[ADDR_W-1:DATA_W] <= s_data;
            sum                    <= csum_total;
          end
          LEN_LO: begin
            len_lo <= s_data;
            sum    <= csum_total;
          end
          LEN_HI: begin
            remaining <= frame_len;
            sum       <= csum_total;
          end
          DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= waddr;
            mem_wdata <= s_data;
            waddr     <= waddr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            sum       <= csum_total;
          end
          CSUM: begin
            cpu_hold <= 1'b0;
            if (csum_total == '0) begin
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : directed self-checking bench for prog_loader
// Revision 1.0
// ============================================================================
`default_nettype none

`define CHK(tag, obs, exp) \
  begin \
    vectors++; \
    assert ((obs) === (exp)) else begin \
      miscompares++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_prog_loader;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fr[$];
  logic [23:0] wlog[$];
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          both_seen = 1'b0;
  int          d0;
  int          e0;

  prog_loader #(
    .TIMEOUT (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    if (load_done) done_cnt++;
    if (load_err) err_cnt++;
    if (load_done && load_err) both_seen = 1'b1;
  end

  // drives fr back-to-back; bytes before hold_from are pre-sync garbage
  task automatic send_frame(input int hold_from);
    for (int i = 0; i < fr.size(); i++) begin
      s_data  = fr[i];
      s_valid = 1'b1;
      @(posedge clock);
      #1;
      if (i < hold_from) begin
        `CHK("idle_hold", cpu_hold, 1'b0)
      end else if (i == hold_from) begin
        `CHK("sync_hold", cpu_hold, 1'b1)
        `CHK("sync_err_clr", err_code, 2'd0)
      end else if (i < fr.size() - 1) begin
        `CHK("frame_hold", cpu_hold, 1'b1)
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    `CHK("rst_ready", s_ready, 1'b0)
    `CHK("rst_we", mem_we, 1'b0)
    `CHK("rst_addr", mem_addr, 16'h0000)
    `CHK("rst_hold", cpu_hold, 1'b0)
    `CHK("rst_err", err_code, 2'd0)
    reset = 1'b0;
    @(posedge clock);
    #1;
    `CHK("ready_after_rst", s_ready, 1'b1)

    // good frame
    wlog.delete(); d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h00, 8'h3C, 8'h7E, 8'h34};
    send_frame(0);
    `CHK("good_done", load_done, 1'b1)
    `CHK("good_err", load_err, 1'b0)
    `CHK("good_hold_drop", cpu_hold, 1'b0)
    `CHK("good_code", err_code, 2'd0)
    `CHK("good_we_off", mem_we, 1'b0)
    `CHK("good_nwr", wlog.size(), 2)
    `CHK("good_w0", wlog[0], 24'h10003C)
    `CHK("good_w1", wlog[1], 24'h10017E)
    @(posedge clock);
    #1;
    `CHK("good_pulse_1cyc", load_done, 1'b0)
    `CHK("good_done_cnt", done_cnt, d0 + 1)
    `CHK("good_err_cnt", err_cnt, e0)

    // bad checksum
    wlog.delete(); d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h00, 8'h3C, 8'h7E, 8'h35};
    send_frame(0);
    `CHK("bad_err", load_err, 1'b1)
    `CHK("bad_done", load_done, 1'b0)
    `CHK("bad_code", err_code, 2'd1)
    `CHK("bad_hold", cpu_hold, 1'b0)
    `CHK("bad_nwr", wlog.size(), 2)
    `CHK("bad_w1", wlog[1], 24'h10017E)
    @(posedge clock);
    #1;
    `CHK("bad_code_held", err_code, 2'd1)
    `CHK("bad_done_cnt", done_cnt, d0)
    `CHK("bad_err_cnt", err_cnt, e0 + 1)

    // address wrap
    wlog.delete(); d0 = done_cnt;
    fr = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'hCD};
    send_frame(0);
    `CHK("wrap_done", load_done, 1'b1)
    `CHK("wrap_nwr", wlog.size(), 2)
    `CHK("wrap_w0", wlog[0], 24'hFFFF11)
    `CHK("wrap_w1", wlog[1], 24'h000022)

    // zero length preceded by garbage
    @(posedge clock);
    #1;
    wlog.delete(); d0 = done_cnt;
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h34, 8'h12, 8'h00, 8'h00, 8'hBA};
    send_frame(2);
    `CHK("zero_done", load_done, 1'b1)
    `CHK("zero_nwr", wlog.size(), 0)
    `CHK("zero_hold", cpu_hold, 1'b0)

    // timeout after the address bytes
    @(posedge clock);
    #1;
    d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h10};
    send_frame(0);
    repeat (TO - 1) @(posedge clock);
    #1;
    `CHK("to_not_yet", load_err, 1'b0)
    `CHK("to_hold_pre", cpu_hold, 1'b1)
    @(posedge clock);
    #1;
    `CHK("to_err", load_err, 1'b1)
    `CHK("to_code", err_code, 2'd2)
    `CHK("to_hold", cpu_hold, 1'b0)
    @(posedge clock);
    #1;
    `CHK("to_err_cnt", err_cnt, e0 + 1)
    `CHK("to_code_held", err_code, 2'd2)

    // recovery frame clears err_code at its sync
    wlog.delete(); d0 = done_cnt;
    fr = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h00, 8'h3C, 8'h7E, 8'h34};
    send_frame(0);
    `CHK("rec_done", load_done, 1'b1)
    `CHK("rec_nwr", wlog.size(), 2)

    // reset in the middle of a 4-byte payload
    @(posedge clock);
    #1;
    d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h20, 8'h04, 8'h00, 8'h01, 8'h02};
    send_frame(0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    `CHK("mid_ready", s_ready, 1'b0)
    `CHK("mid_we", mem_we, 1'b0)
    `CHK("mid_addr", mem_addr, 16'h0000)
    `CHK("mid_wdata", mem_wdata, 8'h00)
    `CHK("mid_hold", cpu_hold, 1'b0)
    `CHK("mid_done", load_done, 1'b0)
    `CHK("mid_err", load_err, 1'b0)
    `CHK("mid_code", err_code, 2'd0)
    reset = 1'b0;
    @(posedge clock);
    #1;
    `CHK("mid_ready_back", s_ready, 1'b1)
    `CHK("mid_no_done", done_cnt, d0)
    `CHK("mid_no_err", err_cnt, e0)

    wlog.delete(); d0 = done_cnt;
    fr = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h00, 8'h3C, 8'h7E, 8'h34};
    send_frame(0);
    `CHK("post_done", load_done, 1'b1)
    `CHK("post_w0", wlog[0], 24'h10003C)
    @(posedge clock);
    #1;
    `CHK("never_both", both_seen, 1'b0)

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`undef CHK

`default_nettype wire
